// File: rtl/rx_sync_sequencer.sv
// rx_sync_sequencer: bring-up and recovery controller for the RX second-half
// datapath (elastic buffers, block aligners, lane deskew, descramblers).
// Sequences soft resets and enables, waits for per-lane valid and deskew
// completion, declares lock or retries on alignment/deskew errors.
// Optional build macro RX_SYNC_LOSS_CNT_EN adds an 8-bit lock_loss_count
// output that counts LOCKED->RETRY transitions (saturating, reset-only clear).
// Every control output is registered from the next-state decode, so a
// decision taken in cycle N is visible in cycle N+1.

module rx_sync_sequencer #(
  parameter int unsigned MAX_LANES     = 32,
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned STABLE_CYCLES = 8,
  parameter int unsigned TIMEOUT       = 1024,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned TMR_WIDTH     = 11
) (
  input  logic                 local_clk,
  input  logic                 local_rst,
  input  logic                 start,
  input  logic                 GEN,
  input  logic [MAX_LANES-1:0] lane_mask,
  input  logic [MAX_LANES-1:0] deskewed_RX_valid,
  input  logic [MAX_LANES-1:0] BA_error,
  input  logic                 valid_deskew,
  input  logic                 Deskew_error,
  output logic                 Soft_RST_blocks,
  output logic                 rst_BA,
  output logic                 PIPE_CNT_rst,
  output logic                 enable,
  output logic                 enable_ltssm,
  output logic                 link_locked,
  output logic                 sync_fail,
  output logic [1:0]           retry_count,
  output logic [2:0]           state_o
`ifdef RX_SYNC_LOSS_CNT_EN
  ,
  output logic [7:0]           lock_loss_count
`endif
);

  localparam int unsigned STB_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned RC_W  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_ALIGN  = 3'd2,
    ST_DESKEW = 3'd3,
    ST_LOCKED = 3'd4,
    ST_RETRY  = 3'd5,
    ST_FAIL   = 3'd6
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [TMR_WIDTH-1:0]   r_timer;
  logic [TMR_WIDTH-1:0]   w_timer_nxt;
  logic [STB_W-1:0]       r_stable;
  logic [STB_W-1:0]       w_stable_nxt;
  logic [MAX_LANES-1:0]   r_mask_q;
  logic [MAX_LANES-1:0]   w_mask_nxt;
  logic                   r_gen;
  logic                   w_gen_nxt;
  logic [RC_W-1:0]        r_retry_count;
  logic [RC_W-1:0]        w_retry_nxt;

  logic                   r_soft_rst;
  logic                   r_rst_ba;
  logic                   r_pipe_rst;
  logic                   r_enable;
  logic                   r_enable_ltssm;
  logic                   r_link_locked;
  logic                   r_sync_fail;

  logic                   w_soft_rst_nxt;
  logic                   w_rst_ba_nxt;
  logic                   w_pipe_rst_nxt;
  logic                   w_enable_nxt;
  logic                   w_enable_ltssm_nxt;
  logic                   w_link_locked_nxt;
  logic                   w_sync_fail_nxt;

  logic                   w_masked_ba;
  logic                   w_all_valid;
  logic                   w_timeout;
  logic                   w_rst_done;
  logic                   w_gen_chg;
  logic                   w_stable_done;
  logic                   w_retry_max;

  // Condition decode on masked lanes; unmasked lanes never influence anything
  assign w_masked_ba   = |(BA_error & r_mask_q);
  assign w_all_valid   = ((deskewed_RX_valid & r_mask_q) == r_mask_q);
  assign w_timeout     = (r_timer == TMR_WIDTH'(TIMEOUT - 1));
  assign w_rst_done    = (r_timer == TMR_WIDTH'(RST_CYCLES - 1));
  assign w_gen_chg     = (GEN != r_gen);
  assign w_stable_done = w_all_valid && (r_stable == STB_W'(STABLE_CYCLES - 1));
  assign w_retry_max   = (r_retry_count == RC_W'(MAX_RETRIES));

  // Next-state, bookkeeping and output decode
  always_comb begin
    w_state_nxt        = r_state;
    w_mask_nxt         = r_mask_q;
    w_retry_nxt        = r_retry_count;
    w_stable_nxt       = '0;
    w_gen_nxt          = r_gen;
    w_soft_rst_nxt     = 1'b0;
    w_rst_ba_nxt       = 1'b0;
    w_pipe_rst_nxt     = 1'b0;
    w_enable_nxt       = 1'b0;
    w_enable_ltssm_nxt = 1'b0;
    w_link_locked_nxt  = 1'b0;
    w_sync_fail_nxt    = 1'b0;

    // GEN is tracked until the datapath leaves RESET; afterwards a change retries
    if ((r_state == ST_IDLE) || (r_state == ST_RESET)) begin
      w_gen_nxt = GEN;
    end

    if ((r_state != ST_IDLE) && !start) begin
      w_state_nxt = ST_IDLE;
      w_retry_nxt = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start && (lane_mask != '0)) begin
            w_state_nxt = ST_RESET;
            w_mask_nxt  = lane_mask;
          end
        end
        ST_RESET: begin
          if (w_rst_done) begin
            w_state_nxt = GEN ? ST_ALIGN : ST_LOCKED;
          end
        end
        ST_ALIGN: begin
          if (w_masked_ba || w_timeout || w_gen_chg) begin
            w_state_nxt = ST_RETRY;
          end else if (w_stable_done) begin
            w_state_nxt = ST_DESKEW;
          end else if (w_all_valid) begin
            w_stable_nxt = r_stable + STB_W'(1);
          end
        end
        ST_DESKEW: begin
          if (Deskew_error || w_masked_ba || w_timeout || w_gen_chg) begin
            w_state_nxt = ST_RETRY;
          end else if (valid_deskew) begin
            w_state_nxt = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          // Retry budget is refunded once the link has held lock for a cycle
          w_retry_nxt = '0;
          if (w_gen_chg || (r_gen && (w_masked_ba || Deskew_error))) begin
            w_state_nxt = ST_RETRY;
          end
        end
        ST_RETRY: begin
          if (w_retry_max) begin
            w_state_nxt = ST_FAIL;
          end else begin
            w_state_nxt = ST_RESET;
            if (r_retry_count != '1) begin
              w_retry_nxt = r_retry_count + RC_W'(1);
            end
          end
        end
        ST_FAIL: begin
          w_state_nxt = ST_FAIL;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    // Control outputs follow the state being entered
    unique case (w_state_nxt)
      ST_RESET: begin
        w_soft_rst_nxt = 1'b1;
        w_rst_ba_nxt   = 1'b1;
        w_pipe_rst_nxt = 1'b1;
      end
      ST_ALIGN: begin
        w_enable_nxt = 1'b1;
      end
      ST_DESKEW: begin
        w_enable_nxt       = 1'b1;
        w_enable_ltssm_nxt = 1'b1;
      end
      ST_LOCKED: begin
        w_link_locked_nxt  = 1'b1;
        w_enable_nxt       = GEN;
        w_enable_ltssm_nxt = GEN;
      end
      ST_FAIL: begin
        w_sync_fail_nxt = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Timer restarts on every state change and saturates instead of wrapping
  always_comb begin
    w_timer_nxt = r_timer;
    if (w_state_nxt != r_state) begin
      w_timer_nxt = '0;
    end else if (r_timer != '1) begin
      w_timer_nxt = r_timer + TMR_WIDTH'(1);
    end
  end

  // State, bookkeeping and registered control outputs
  always_ff @(posedge local_clk) begin
    if (!local_rst) begin
      r_state        <= ST_IDLE;
      r_timer        <= '0;
      r_stable       <= '0;
      r_mask_q       <= '0;
      r_gen          <= 1'b0;
      r_retry_count  <= '0;
      r_soft_rst     <= 1'b0;
      r_rst_ba       <= 1'b0;
      r_pipe_rst     <= 1'b0;
      r_enable       <= 1'b0;
      r_enable_ltssm <= 1'b0;
      r_link_locked  <= 1'b0;
      r_sync_fail    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_timer        <= w_timer_nxt;
      r_stable       <= w_stable_nxt;
      r_mask_q       <= w_mask_nxt;
      r_gen          <= w_gen_nxt;
      r_retry_count  <= w_retry_nxt;
      r_soft_rst     <= w_soft_rst_nxt;
      r_rst_ba       <= w_rst_ba_nxt;
      r_pipe_rst     <= w_pipe_rst_nxt;
      r_enable       <= w_enable_nxt;
      r_enable_ltssm <= w_enable_ltssm_nxt;
      r_link_locked  <= w_link_locked_nxt;
      r_sync_fail    <= w_sync_fail_nxt;
    end
  end

`ifdef RX_SYNC_LOSS_CNT_EN
  logic [7:0] r_lock_loss_count;

  // Lifetime count of lock losses; only the hard reset clears it
  always_ff @(posedge local_clk) begin
    if (!local_rst) begin
      r_lock_loss_count <= '0;
    end else if ((r_state == ST_LOCKED) && (w_state_nxt == ST_RETRY) &&
                 (r_lock_loss_count != 8'hFF)) begin
      r_lock_loss_count <= r_lock_loss_count + 8'd1;
    end
  end

  assign lock_loss_count = r_lock_loss_count;
`endif

  assign Soft_RST_blocks = r_soft_rst;
  assign rst_BA          = r_rst_ba;
  assign PIPE_CNT_rst    = r_pipe_rst;
  assign enable          = r_enable;
  assign enable_ltssm    = r_enable_ltssm;
  assign link_locked     = r_link_locked;
  assign sync_fail       = r_sync_fail;
  assign retry_count     = r_retry_count;
  assign state_o         = r_state;

endmodule

// File: tb/tb_rx_sync_sequencer.sv
// Directed bench for rx_sync_sequencer: the driver pushes hand-computed
// expectations tagged with a cycle number, a monitor pops and compares them.
module tb_rx_sync_sequencer;

  localparam int unsigned LANES = 32;

  // Expected control-output vectors {soft,rst_ba,pipe,en,en_ltssm,locked,fail}
  localparam logic [6:0] O_IDLE = 7'b000_00_0_0;
  localparam logic [6:0] O_RST  = 7'b111_00_0_0;
  localparam logic [6:0] O_ALN  = 7'b000_10_0_0;
  localparam logic [6:0] O_DSK  = 7'b000_11_0_0;
  localparam logic [6:0] O_LCK1 = 7'b000_11_1_0;
  localparam logic [6:0] O_LCK0 = 7'b000_00_1_0;
  localparam logic [6:0] O_FAIL = 7'b000_00_0_1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             gen;
  logic [LANES-1:0] lane_mask;
  logic [LANES-1:0] dvalid;
  logic [LANES-1:0] ba_err;
  logic             vdesk;
  logic             desk_err;
  logic             soft_rst, rst_ba, pipe_rst, en, en_ltssm, locked, sfail;
  logic [1:0]       rc;
  logic [2:0]       st;
`ifdef RX_SYNC_LOSS_CNT_EN
  logic [7:0]       llc;
`endif

  rx_sync_sequencer dut (
    .local_clk         (clk),
    .local_rst         (rst_n),
    .start             (start),
    .GEN               (gen),
    .lane_mask         (lane_mask),
    .deskewed_RX_valid (dvalid),
    .BA_error          (ba_err),
    .valid_deskew      (vdesk),
    .Deskew_error      (desk_err),
    .Soft_RST_blocks   (soft_rst),
    .rst_BA            (rst_ba),
    .PIPE_CNT_rst      (pipe_rst),
    .enable            (en),
    .enable_ltssm      (en_ltssm),
    .link_locked       (locked),
    .sync_fail         (sfail),
    .retry_count       (rc),
    .state_o           (st)
`ifdef RX_SYNC_LOSS_CNT_EN
    ,
    .lock_loss_count   (llc)
`endif
  );

  typedef struct {
    string      name;
    int         cyc;
    logic [2:0] st;
    logic [6:0] outs;
    logic [1:0] rc;
    logic       chk_llc;
    logic [7:0] llc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation scheduled for the current cycle
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      exp_t       e;
      logic [6:0] got_o;
      logic       bad;
      e     = sb_q.pop_front();
      got_o = {soft_rst, rst_ba, pipe_rst, en, en_ltssm, locked, sfail};
      bad   = (st !== e.st) || (got_o !== e.outs) || (rc !== e.rc) || (e.cyc != cyc);
`ifdef RX_SYNC_LOSS_CNT_EN
      if (e.chk_llc && (llc !== e.llc)) bad = 1'b1;
`endif
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s: got st=%0d outs=%b rc=%0d, expected st=%0d outs=%b rc=%0d llc=%0d (cyc %0d/%0d)",
                 e.name, st, got_o, rc, e.st, e.outs, e.rc, e.llc, cyc, e.cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string name, input logic [2:0] s,
                           input logic [6:0] o, input logic [1:0] r);
    exp_t e;
    e.name = name; e.cyc = cyc; e.st = s; e.outs = o; e.rc = r;
    e.chk_llc = 1'b0; e.llc = 8'd0;
    sb_q.push_back(e);
  endtask

  task automatic expect_llc(input string name, input logic [2:0] s,
                            input logic [6:0] o, input logic [1:0] r,
                            input logic [7:0] l);
    exp_t e;
    e.name = name; e.cyc = cyc; e.st = s; e.outs = o; e.rc = r;
    e.chk_llc = 1'b1; e.llc = l;
    sb_q.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; gen = 1'b0; lane_mask = '0;
    dvalid = '0; ba_err = '0; vdesk = 1'b0; desk_err = 1'b0;
    step(2);
    expect_st("reset", 3'd0, O_IDLE, 2'd0);
    rst_n = 1'b1;

    // Empty lane mask keeps IDLE
    start = 1'b1;
    step(2);
    expect_st("idle_mask0", 3'd0, O_IDLE, 2'd0);

    // Gen3 bring-up: 4 reset cycles, 8 stable cycles, deskew pulse
    gen = 1'b1; lane_mask = 32'h0000_000F;
    for (int i = 0; i < 4; i++) begin
      step(1);
      expect_st("t1_reset", 3'd1, O_RST, 2'd0);
    end
    step(1);
    expect_st("t1_align", 3'd2, O_ALN, 2'd0);
    dvalid = 32'h0000_000F;
    step(7);
    expect_st("t1_align_stab7", 3'd2, O_ALN, 2'd0);
    step(1);
    expect_st("t1_deskew", 3'd3, O_DSK, 2'd0);
    step(2);
    expect_st("t1_deskew_wait", 3'd3, O_DSK, 2'd0);
    vdesk = 1'b1;
    step(1);
    expect_st("t1_locked", 3'd4, O_LCK1, 2'd0);
    vdesk = 1'b0;

    // Unmasked BA error ignored, masked one retries
    ba_err = 32'h0000_0020;
    step(1);
    expect_st("t3_unmasked_ba", 3'd4, O_LCK1, 2'd0);
    ba_err = 32'h0000_0004;
    step(1);
    expect_st("t3_retry", 3'd5, O_IDLE, 2'd0);
    ba_err = '0;
    step(1);
    expect_st("t3_reset_rc1", 3'd1, O_RST, 2'd1);
    step(4);
    expect_st("t3_align", 3'd2, O_ALN, 2'd1);
    step(8);
    expect_st("t3_deskew", 3'd3, O_DSK, 2'd1);
    vdesk = 1'b1;
    step(1);
    expect_st("t3_locked_rc_hold", 3'd4, O_LCK1, 2'd1);
    vdesk = 1'b0;
    step(1);
    expect_st("t3_locked_rc_clr", 3'd4, O_LCK1, 2'd0);

    // Deskew_error in LOCKED, then deskew valid+error collision
    desk_err = 1'b1;
    step(1);
    expect_st("t5_lock_deskew_err", 3'd5, O_IDLE, 2'd0);
    desk_err = 1'b0;
    step(1);
    expect_st("t5_reset", 3'd1, O_RST, 2'd1);
    step(4);
    expect_st("t5_align", 3'd2, O_ALN, 2'd1);
    step(8);
    expect_st("t5_deskew", 3'd3, O_DSK, 2'd1);
    vdesk = 1'b1; desk_err = 1'b1;
    step(1);
    expect_st("t5_error_wins", 3'd5, O_IDLE, 2'd1);
    vdesk = 1'b0; desk_err = 1'b0;
    step(1);
    expect_st("t5_reset_rc2", 3'd1, O_RST, 2'd2);
    step(4);
    expect_st("t5_align2", 3'd2, O_ALN, 2'd2);
    step(2);
    start = 1'b0;
    step(1);
    expect_st("t5_abort_align", 3'd0, O_IDLE, 2'd0);

    // 8b/10b path: straight to LOCKED, errors ignored, GEN change retries
    gen = 1'b0; lane_mask = 32'h0000_0001; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      expect_st("t2_reset", 3'd1, O_RST, 2'd0);
    end
    step(1);
    expect_st("t2_locked", 3'd4, O_LCK0, 2'd0);
    ba_err = 32'h0000_0001; desk_err = 1'b1;
    step(1);
    expect_st("t2_err_ignored", 3'd4, O_LCK0, 2'd0);
    ba_err = '0; desk_err = 1'b0; gen = 1'b1;
    step(1);
    expect_st("t2_gen_change", 3'd5, O_IDLE, 2'd0);
    start = 1'b0;
    step(1);
    expect_st("t2_abort", 3'd0, O_IDLE, 2'd0);

    // Synchronous reset in the middle of RESET
    gen = 1'b1; lane_mask = 32'h0000_000F; start = 1'b1;
    step(1);
    expect_st("t6_reset", 3'd1, O_RST, 2'd0);
    step(1);
    rst_n = 1'b0;
    step(1);
    expect_st("t6_rst_abort", 3'd0, O_IDLE, 2'd0);
    rst_n = 1'b1; start = 1'b0;
    step(1);

    // Align timeouts until retries are exhausted
    dvalid = 32'h0000_0007; start = 1'b1;
    step(1);
    expect_st("t4_reset_r0", 3'd1, O_RST, 2'd0);
    for (int k = 0; k < 4; k++) begin
      step(4);
      expect_st("t4_align", 3'd2, O_ALN, 2'(k));
      step(1023);
      expect_st("t4_align_last", 3'd2, O_ALN, 2'(k));
      step(1);
      expect_st("t4_retry", 3'd5, O_IDLE, 2'(k));
      step(1);
      if (k < 3) expect_st("t4_reset_next", 3'd1, O_RST, 2'(k + 1));
      else       expect_st("t4_fail", 3'd6, O_FAIL, 2'd3);
    end
    step(5);
    expect_st("t4_fail_hold", 3'd6, O_FAIL, 2'd3);
    start = 1'b0;
    step(1);
    expect_st("t4_fail_exit", 3'd0, O_IDLE, 2'd0);

`ifdef RX_SYNC_LOSS_CNT_EN
    // 300 forced lock losses saturate the loss counter at 255
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    gen = 1'b1; lane_mask = 32'h0000_0001; dvalid = '1; vdesk = 1'b1; start = 1'b1;
    for (int n = 0; n < 300; n++) begin
      int budget;
      budget = 64;
      while (st != 3'd4 && budget > 0) begin
        step(1);
        budget--;
      end
      if (budget == 0) begin
        checks++; errors++;
        $display("FAIL llc_relock: got st=%0d, expected LOCKED within 64 cycles", st);
        break;
      end
      if (n == 3) expect_llc("llc_three", 3'd4, O_LCK1, rc, 8'd3);
      ba_err = 32'h0000_0001;
      step(1);
      ba_err = '0;
    end
    vdesk = 1'b0; start = 1'b0;
    step(1);
    expect_llc("llc_saturated", 3'd0, O_IDLE, 2'd0, 8'd255);
`endif

    step(2);
    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
